// File: rtl/ucie_ctl_sb_rx_deser_if.sv
// ucie_ctl_sb_rx_deser_if: beat input and word output bundle of the sideband RX deserializer
//  pl_cfg/pl_cfg_vld              NC-bit config beat and its valid (driven by master)
//  received_data/count_done       last completed word and its one-cycle strobe
//  beat_cnt/busy/word_idx         partial-word progress and phase index of received_data
interface ucie_ctl_sb_rx_deser_if #(parameter int NC = 8);
  logic [NC-1:0] pl_cfg;
  logic          pl_cfg_vld;
  logic [31:0]   received_data;
  logic          count_done;
  logic [4:0]    beat_cnt;
  logic          busy;
  logic [1:0]    word_idx;
  modport master (output pl_cfg, pl_cfg_vld, input received_data, count_done, beat_cnt, busy, word_idx);
  modport slave (input pl_cfg, pl_cfg_vld, output received_data, count_done, beat_cnt, busy, word_idx);
endinterface

// File: rtl/ucie_ctl_sb_rx_deser.sv
// ucie_ctl_sb_rx_deser: packs NC-bit sideband config beats (LSB beat first) into 32-bit phase words
//  i_clk, i_rst   clock, synchronous active-high reset
//  bus (slave)    pl_cfg/pl_cfg_vld in; received_data, count_done, beat_cnt, busy, word_idx out
//  Optional macro UCIE_SB_RX_WORD_IDX_EN builds the per-message phase index; otherwise word_idx is 0.
module ucie_ctl_sb_rx_deser #(
  parameter int NC = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  ucie_ctl_sb_rx_deser_if.slave bus
);
  localparam int BEATS = 32 / NC;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t      state, state_nx;
  logic [31:0] shreg, word;
  logic [4:0]  cnt, cnt_nx;
  logic        last, done_nx;
  // The incoming beat is merged into the shift register at its final bit position,
  // so word is the completed word whenever the current beat is the last one.
  // With BEATS==1 cnt stays 0, last is always true and IDLE completes directly.
  always_comb begin
    word = shreg;
    word[cnt*NC +: NC] = bus.pl_cfg;
    last = (cnt == 5'(BEATS - 1));
    done_nx = bus.pl_cfg_vld && last;
    cnt_nx = (bus.pl_cfg_vld && !last) ? cnt + 5'd1 : 5'd0;
    state_nx = (bus.pl_cfg_vld && !last) ? COLLECT : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      bus.received_data <= '0;
      bus.count_done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (bus.pl_cfg_vld && !last) shreg <= word;
      if (done_nx) bus.received_data <= word;
      bus.count_done <= done_nx;
    end
  end
  assign bus.beat_cnt = cnt;
  assign bus.busy = (state == COLLECT);
`ifdef UCIE_SB_RX_WORD_IDX_EN
  // nxt is the index the next completed word will carry; a valid-low cycle in IDLE
  // marks a message boundary and restarts numbering from 0.
  logic [1:0] idx, nxt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx <= '0;
      nxt <= '0;
    end else if (done_nx) begin
      idx <= nxt;
      nxt <= nxt + 2'd1;
    end else if (!bus.pl_cfg_vld && state == IDLE) begin
      idx <= '0;
      nxt <= '0;
    end
  end
  assign bus.word_idx = idx;
`else
  assign bus.word_idx = 2'b00;
`endif
endmodule

// File: tb/tb_ucie_ctl_sb_rx_deser.sv
// tb_ucie_ctl_sb_rx_deser: NC=8 and NC=32 deserializers against a beat-list reference model
module tb_ucie_ctl_sb_rx_deser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [31:0] d = '0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;

  ucie_ctl_sb_rx_deser_if #(.NC(8)) b8();
  ucie_ctl_sb_rx_deser_if #(.NC(32)) b32();
  assign b8.pl_cfg = d[7:0];
  assign b8.pl_cfg_vld = vld;
  assign b32.pl_cfg = d;
  assign b32.pl_cfg_vld = vld;
  ucie_ctl_sb_rx_deser #(.NC(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(b8.slave));
  ucie_ctl_sb_rx_deser #(.NC(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32.slave));

  // Reference: beats collected so far, the word they form, and the message word count.
  typedef struct packed {
    logic [5:0]  cnt;
    logic [31:0] part;
    logic [31:0] rx;
    logic        done;
    logic [1:0]  idx;
    logic [1:0]  nxt;
  } ms_t;
  ms_t m8 = '0;
  ms_t m32 = '0;

  function automatic ms_t step(ms_t s, int nc, logic r, logic v, logic [31:0] dat);
    ms_t n = s;
    logic [31:0] beat = (nc == 32) ? dat : dat & ((32'd1 << nc) - 32'd1);
    n.done = 1'b0;
    if (r) return '0;
    if (v) begin
      n.part = ((s.cnt == 0) ? 32'd0 : s.part) | (beat << (s.cnt * nc));
      if (int'(s.cnt) + 1 == 32 / nc) begin
        n.rx = n.part;
        n.done = 1'b1;
        n.cnt = '0;
        n.idx = s.nxt;
        n.nxt = s.nxt + 2'd1;
      end else n.cnt = s.cnt + 6'd1;
    end else begin
      n.cnt = '0;
      if (s.cnt == 0) begin
        n.idx = '0;
        n.nxt = '0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m8 <= step(m8, 8, rst, vld, d);
    m32 <= step(m32, 32, rst, vld, d);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_idx(ms_t s);
`ifdef UCIE_SB_RX_WORD_IDX_EN
    return s.idx;
`else
    return 2'b00 & s.idx;
`endif
  endfunction

  always @(negedge clk) begin
    chk("rx8", b8.received_data, m8.rx);
    chk("done8", 32'(b8.count_done), 32'(m8.done));
    chk("cnt8", 32'(b8.beat_cnt), 32'(m8.cnt));
    chk("busy8", 32'(b8.busy), 32'(m8.cnt != 0));
    chk("idx8", 32'(b8.word_idx), 32'(exp_idx(m8)));
    chk("rx32", b32.received_data, m32.rx);
    chk("done32", 32'(b32.count_done), 32'(m32.done));
    chk("cnt32", 32'(b32.beat_cnt), 32'(m32.cnt));
    chk("busy32", 32'(b32.busy), 32'(m32.cnt != 0));
    chk("idx32", 32'(b32.word_idx), 32'(exp_idx(m32)));
  end

  task automatic drive(input logic v, input logic [31:0] x);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vld = v;
    d = x;
  endtask

  logic [7:0] t2 [8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] t3 [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rx", b8.received_data, 32'h0);
    chk("reset_busy", 32'(b8.busy), 32'h0);
    // T1
    drive(1'b1, 32'h78);
    drive(1'b1, 32'h56);
    drive(1'b1, 32'h34);
    drive(1'b1, 32'h12);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t1_data", b8.received_data, 32'h12345678);
    chk("t1_done", 32'(b8.count_done), 32'h1);
    chk("t1_cnt", 32'(b8.beat_cnt), 32'h0);
    // T2
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(t2[i]));
      if (i == 4) begin
        @(negedge clk);
        chk("t2_w0", b8.received_data, 32'hDEADBEEF);
        chk("t2_busy", 32'(b8.busy), 32'h0);
      end
    end
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t2_w1", b8.received_data, 32'h00000001);
    // T3
    drive(1'b1, 32'h11);
    drive(1'b1, 32'h22);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t3_hold", b8.received_data, 32'h00000001);
    chk("t3_nodone", 32'(b8.count_done), 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(t3[i]));
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t3_data", b8.received_data, 32'hCAFEF00D);
    // T4
    drive(1'b1, 32'hAA);
    drive(1'b1, 32'hBB);
    @(posedge clk);
    #1;
    rst = 1'b1;
    vld = 1'b1;
    d = 32'hCC;
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t4_rx", b8.received_data, 32'h0);
    chk("t4_cnt", 32'(b8.beat_cnt), 32'h0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i));
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t4_word", b8.received_data, 32'h04030201);
    // T5 on the NC=32 instance
    drive(1'b1, 32'h11111111);
    drive(1'b1, 32'h22222222);
    @(negedge clk);
    chk("t5_w0", b32.received_data, 32'h11111111);
    drive(1'b1, 32'h33333333);
    @(negedge clk);
    chk("t5_w1", b32.received_data, 32'h22222222);
    chk("t5_done", 32'(b32.count_done), 32'h1);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("t5_w2", b32.received_data, 32'h33333333);
    chk("t5_busy", 32'(b32.busy), 32'h0);
    // T6: five back-to-back words, a boundary, then one word
    for (int i = 0; i < 20; i++) drive(1'b1, 32'($urandom_range(0, 255)));
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'($urandom_range(0, 255)));
    drive(1'b0, 32'h0);
    // Random traffic with long valid runs and rare resets
    repeat (3000) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      vld = ($urandom_range(0, 9) != 0);
      d = $urandom;
    end
    drive(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
